uart_tx_frame_controller: RTL

Sequences one UART transmit frame per accepted byte: start bit, 5–8 data bits LSB first, optional parity, then 1 or 2 stop bits. It generates its own oversampled bit timing from a clock divisor and an oversampling factor. It sits between the TX packet source (valid/ready) and the serial line. It supports parity and framing error injection for verification.

---
 rtl/uart_tx_frame_controller.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_controller.sv
// UART transmit framer: start, 5..8 data bits LSB first, optional parity,
// 1..2 stop bits, with oversampled bit timing and error injection.
// Ports:
//   cfg*  : frame config, sanitised and latched per accepted byte
//   txData, txValid / txReady : byte handshake
//   tx, busy, frameDone, state : serial line and status
module uart_tx_frame_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            cfgDataBits,
  input  logic                  cfgParityEnable,
  input  logic                  cfgParityOdd,
  input  logic [1:0]            cfgStopBits,
  input  logic [4:0]            cfgOverSampling,
  input  logic [DIV_WIDTH-1:0]  cfgBaudDivisor,
  input  logic                  cfgParityErrInject,
  input  logic                  cfgFramingErrInject,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  txValid,
  output logic                  txReady,
  output logic                  tx,
  output logic                  busy,
  output logic                  frameDone,
  output logic [2:0]            state
);

  localparam int IW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_tx;
  logic   w_tx_nxt;
  logic   r_done;
  logic   w_done_nxt;

  logic [DATA_WIDTH-1:0] r_data;
  logic [IW-1:0]         r_last;
  logic                  r_par_en;
  logic                  r_par_odd;
  logic                  r_two_stop;
  logic [4:0]            r_os_m1;
  logic [DIV_WIDTH-1:0]  r_div_m1;
  logic                  r_perr;
  logic                  r_ferr;

  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [4:0]            r_tick_cnt;
  logic [IW-1:0]         r_bit_idx;
  logic                  r_stop_idx;

  logic                  w_xfer;
  logic                  w_tick;
  logic                  w_bit_end;
  logic [IW-1:0]         w_bit_nxt;
  logic [3:0]            w_nbits;
  logic [3:0]            w_last;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_parity;

  assign txReady   = (r_state == ST_RESET) && reset;
  assign w_xfer    = txValid && txReady;
  assign w_tick    = (r_div_cnt == r_div_m1);
  assign w_bit_end = w_tick && (r_tick_cnt == r_os_m1);
  assign w_bit_nxt = r_bit_idx + 1'b1;

  assign tx        = r_tx;
  assign busy      = (r_state != ST_RESET);
  assign frameDone = r_done;
  assign state     = r_state;

  always_comb begin
    w_nbits = cfgDataBits;
    if (cfgDataBits < 4'd5) w_nbits = 4'd5;
    if (cfgDataBits > 4'd8) w_nbits = 4'd8;
    w_last = w_nbits - 4'd1;
  end

  // Only the active low-order bits take part in parity.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      w_mask[i] = (i <= int'(r_last));
    w_parity = ^(r_data & w_mask) ^ r_par_odd ^ r_perr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RESET;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_RESET: begin
        w_tx_nxt = 1'b1;
        if (w_xfer) begin
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_tx_nxt    = r_data[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx != r_last) begin
            w_tx_nxt = r_data[w_bit_nxt];
          end else if (r_par_en) begin
            w_state_nxt = ST_PARITY;
            w_tx_nxt    = w_parity;
          end else begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = ~r_ferr;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = ~r_ferr;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_tx_nxt = 1'b1;
          if (r_stop_idx == r_two_stop) begin
            w_state_nxt = ST_RESET;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data     <= '0;
      r_last     <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
      r_os_m1    <= 5'd15;
      r_div_m1   <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
    end else if (w_xfer) begin
      r_data     <= txData;
      r_last     <= w_last[IW-1:0];
      r_par_en   <= cfgParityEnable;
      r_par_odd  <= cfgParityOdd;
      // 0 and 1 mean one stop bit, 2 and 3 mean two.
      r_two_stop <= cfgStopBits[1];
      r_os_m1    <= (cfgOverSampling == 5'd13) ? 5'd12 : 5'd15;
      r_div_m1   <= (cfgBaudDivisor == '0) ? '0 : cfgBaudDivisor - 1'b1;
      r_perr     <= cfgParityErrInject;
      r_ferr     <= cfgFramingErrInject;
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
    end else if (r_state != ST_RESET) begin
      if (w_tick) begin
        r_div_cnt  <= '0;
        r_tick_cnt <= w_bit_end ? 5'd0 : r_tick_cnt + 5'd1;
      end else begin
        r_div_cnt  <= r_div_cnt + 1'b1;
      end
      if (w_bit_end && r_state == ST_DATA) r_bit_idx  <= w_bit_nxt;
      if (w_bit_end && r_state == ST_STOP) r_stop_idx <= 1'b1;
    end
  end

endmodule
